shift_add_mult_seq: RTL
=======================

// Module: shift_add_mult_seq
// PURPOSE
//  Parametrised sequential shift-add multiplier: control FSM plus datapath (A, B, X, M).
//  Computes S * B. The WIDTH-bit product high half lands in A, the low half in B, and X holds the sign/carry.
//  Successor of the fixed 8-bit add/shift controller. Adds: WIDTH and signed/unsigned parameters,
//  a latched multiplicand, an iteration counter instead of unrolled states, and Busy/Done handshake.
//  Sits between the switch/button synchronisers and the hex display drivers.
// PARAMETERS
//  WIDTH   8  operand width in bits; legal range 2..32.
//  SIGNED  1  1 = two's-complement (subtract on final iteration, arithmetic shift); 0 = unsigned.
// PORTS
//  Clk           in   1      clock.
//  Reset         in   1      synchronous, active-high reset.
//  Run           in   1      level; start request, sampled in IDLE.
//  ClearA_LoadB  in   1      level; in IDLE: A<=0, X<=0, B<=S.
//  S             in   WIDTH  multiplicand / load value.
//  Aval          out  WIDTH  register A (product high half).
//  Bval          out  WIDTH  register B (multiplier; product low half when done).
//  X             out  1      extension bit (sign if SIGNED=1, carry if SIGNED=0).
//  Busy          out  1      high in ADD and SHIFT states.
//  Done          out  1      high in DONE state.
// BEHAVIOUR
//  Reset: state=IDLE; A, B, M, cnt = 0; X=0; Busy=0; Done=0. Reset overrides every state, including mid-operation.
//  States: IDLE, ADD, SHIFT, DONE. Counter cnt is $clog2(WIDTH) bits.
//  IDLE:
//   ClearA_LoadB=1 has priority: A<=0, X<=0, B<=S; stay in IDLE.
//   Else, if Run=1: A<=0, X<=0, M<=S, cnt<=0; go to ADD if B[0] else SHIFT.
//   S is latched into M at start; later changes on S do not affect the result.
//  ADD (1 cycle): r = {ext(A)} +/- {ext(M)}, a WIDTH+1-bit result.
//   Subtract only when SIGNED=1 and cnt==WIDTH-1; otherwise add.
//   ext = sign-extend when SIGNED=1, zero-extend when SIGNED=0.
//   {X,A} <= r. Next state: SHIFT.
//  SHIFT (1 cycle): B <= {A[0], B[W-1:1]}; A <= {X, A[W-1:1]}.
//   X <= X when SIGNED=1; X <= 0 when SIGNED=0.
//   If cnt==WIDTH-1, go to DONE.
//   Else cnt++, and go to ADD if the post-shift B[0]=1 (i.e. B[1] before the shift), else SHIFT.
//  DONE: holds A, B, X. Stays until Run=0, then goes to IDLE. A held Run does not retrigger.
//  ClearA_LoadB and Run are ignored in ADD, SHIFT and DONE.
//  Latency: Run high in IDLE -> Done high after WIDTH + popcount(B) cycles.
//   An ADD is skipped for every 0 bit of B.
//  Chaining: a new Run without a reload multiplies M' = S by the previous low half already in B.
//  All outputs are registered or pure state decodes; there is no combinational path from inputs to outputs.
// TESTING
//  1. W=8, S=1: ClearA_LoadB=1 then Run.
//     -> A=0, B=S, X=0 in IDLE; Run starts and the unit runs.
//     Reset asserted 3 cycles into the run -> next cycle IDLE, all registers 0, Busy=0.
//  2. W=8, SIGNED=1: load B=0x05, S=0xFD (-3), Run.
//     -> Busy for 10 cycles (8 shifts + 2 adds); Done with A=0xFF, B=0xF1, X=1 (-15).
//  3. W=8, SIGNED=1: B=0x80, S=0x80 (-128*-128).
//     -> final-iteration subtract; 9 busy cycles; A=0x40, B=0x00, X=0 (16384).
//  4. W=8, SIGNED=0: B=0xFF, S=0xFF.
//     -> 16 busy cycles; A=0xFE, B=0x01, X=0 (65025).
//  5. W=16, SIGNED=1: B=0x7FFF, S=0x8000.
//     -> A=0xC000, B=0x8000, X=1. S changed mid-run -> result unchanged.
//  6. Run held high after Done -> FSM stays in DONE, no restart.
//     Drop Run, raise it again -> chained multiply uses B=0xF1 from scenario 2 and S=0x02: A=0xFF, B=0xE2.

Source files
------------

// File: rtl/shift_add_mult_seq_if.sv
// shift_add_mult_seq_if
//   Operand/control and result bundle for the sequential shift-add multiplier.
//   master : drives Run, ClearA_LoadB, S; observes Aval, Bval, X, Busy, Done.
//   slave  : the multiplier side of the same signals.
interface shift_add_mult_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, ClearA_LoadB, S,
    input  Aval, Bval, X, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, S,
    output Aval, Bval, X, Busy, Done
  );
endinterface

// File: rtl/shift_add_mult_seq.sv
// shift_add_mult_seq
//   Sequential shift-add multiplier computing S * B. After WIDTH iterations the
//   product high half is in A, the low half in B, and X holds the sign (SIGNED=1)
//   or is cleared (SIGNED=0). An ADD cycle is only spent for each 1 bit of B.
// Ports
//   Clk    in  clock
//   Reset  in  synchronous, active-high reset
//   bus    slave modport: Run, ClearA_LoadB, S in; Aval, Bval, X, Busy, Done out
//
// state | meaning
// IDLE  | waiting; ClearA_LoadB loads B, Run starts a multiply
// ADD   | {X,A} <= A +/- M
// SHIFT | shift {X,A,B} right one place, advance iteration count
// DONE  | result held until Run is released
module shift_add_mult_seq #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input logic               Clk,
  input logic               Reset,
  shift_add_mult_seq_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             x_q;
  logic [CW-1:0]    cnt;

  logic             last;
  logic             sub;
  logic [WIDTH:0]   a_ext, m_ext, sum;

  assign last  = (cnt == LAST);
  // In two's complement the final multiplier bit carries negative weight.
  assign sub   = SIGNED && last;
  assign a_ext = {(SIGNED ? a_q[WIDTH-1] : 1'b0), a_q};
  assign m_ext = {(SIGNED ? m_q[WIDTH-1] : 1'b0), m_q};
  assign sum   = sub ? (a_ext - m_ext) : (a_ext + m_ext);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!bus.ClearA_LoadB && bus.Run) state_nx = b_q[0] ? ADD : SHIFT;
      ADD:   state_nx = SHIFT;
      // b_q[1] becomes the next multiplier bit once this shift completes.
      SHIFT: if (last) state_nx = DONE;
             else      state_nx = b_q[1] ? ADD : SHIFT;
      DONE:  if (!bus.Run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      x_q <= 1'b0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= bus.S;
          end else if (bus.Run) begin
            a_q <= '0;
            x_q <= 1'b0;
            m_q <= bus.S;
            cnt <= '0;
          end
        end
        ADD: {x_q, a_q} <= sum;
        SHIFT: begin
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
          a_q <= {x_q, a_q[WIDTH-1:1]};
          if (!SIGNED) x_q <= 1'b0;
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.X    = x_q;
  assign bus.Busy = (state == ADD) || (state == SHIFT);
  assign bus.Done = (state == DONE);

endmodule
